// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: tracks in-flight destination registers and gates issue on
// RAW/WAW/capacity hazards. Define SCOREBOARD_PERF_EN to include the stall-cycle counter.
module reg_scoreboard #(
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 issue_valid,
  output logic                                 issue_ready,
  input  logic [4:0]                           issue_rs1_addr,
  input  logic [4:0]                           issue_rs2_addr,
  input  logic                                 issue_rs1_rden,
  input  logic                                 issue_rs2_rden,
  input  logic [4:0]                           issue_rd_addr,
  input  logic                                 issue_rd_wren,
  input  logic [4:0]                           wb_rd_addr,
  input  logic                                 wb_rd_wren,
  input  logic                                 flush,
  output logic [31:0]                          busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]     pending_cnt,
  output logic                                 wb_err,
  output logic [31:0]                          stall_cnt
);

  localparam int unsigned CntW = $clog2(MAX_PENDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_PENDING);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [31:0]     busy_q, busy_d;
  logic [CntW-1:0] pending_q, pending_d;
  logic            wb_err_q, wb_err_d;

  logic wb_act, wb_clr, wb_bad;
  logic raw1, raw2, rd_act, waw, cap, acc_set;

  // Hazard decode: a same-cycle writeback to a source/destination is bypassed by the
  // register file, so it never counts as a hazard.
  always_comb begin
    wb_act  = wb_rd_wren && (wb_rd_addr != 5'd0);
    wb_clr  = wb_act && busy_q[wb_rd_addr];
    wb_bad  = wb_act && !busy_q[wb_rd_addr];
    raw1    = issue_rs1_rden && (issue_rs1_addr != 5'd0) && busy_q[issue_rs1_addr]
              && !(wb_act && (wb_rd_addr == issue_rs1_addr));
    raw2    = issue_rs2_rden && (issue_rs2_addr != 5'd0) && busy_q[issue_rs2_addr]
              && !(wb_act && (wb_rd_addr == issue_rs2_addr));
    rd_act  = issue_rd_wren && (issue_rd_addr != 5'd0);
    waw     = rd_act && busy_q[issue_rd_addr] && !(wb_act && (wb_rd_addr == issue_rd_addr));
    // A retiring writeback frees a slot in the same cycle.
    cap     = rd_act && (pending_q == MaxCnt) && !wb_clr;
    issue_ready = !flush && !raw1 && !raw2 && !waw && !cap;
    acc_set = issue_valid && issue_ready && rd_act;
  end

  always_comb begin
    busy_d    = busy_q;
    pending_d = pending_q;
    wb_err_d  = wb_err_q;
    if (flush) begin
      busy_d    = '0;
      pending_d = '0;
    end else begin
      // Clear before set so a same-register set/clear pair leaves the bit set.
      if (wb_clr) busy_d[wb_rd_addr] = 1'b0;
      if (acc_set) busy_d[issue_rd_addr] = 1'b1;
      unique case ({acc_set, wb_clr})
        2'b10:   pending_d = pending_q + CntOne;
        2'b01:   pending_d = pending_q - CntOne;
        default: pending_d = pending_q;
      endcase
      if (wb_bad) wb_err_d = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      pending_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = pending_q;
  assign wb_err      = wb_err_q;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (issue_valid && !issue_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: next-cycle state expectations are queued with the
// stimulus and compared after the clock edge; combinational issue_ready is checked in-cycle.
module tb_reg_scoreboard;

  localparam int unsigned MaxPending = 4;
  localparam int unsigned CntW = $clog2(MaxPending + 1);
`ifdef SCOREBOARD_PERF_EN
  localparam logic [31:0] PerfExp = 32'd6;
`else
  localparam logic [31:0] PerfExp = 32'd0;
`endif

  logic            clk, rst_n;
  logic            issue_valid, issue_ready;
  logic [4:0]      issue_rs1_addr, issue_rs2_addr, issue_rd_addr, wb_rd_addr;
  logic            issue_rs1_rden, issue_rs2_rden, issue_rd_wren, wb_rd_wren, flush;
  logic [31:0]     busy, stall_cnt;
  logic [CntW-1:0] pending_cnt;
  logic            wb_err;

  reg_scoreboard #(.MAX_PENDING(MaxPending)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs1_addr(issue_rs1_addr),
    .issue_rs2_addr(issue_rs2_addr),
    .issue_rs1_rden(issue_rs1_rden),
    .issue_rs2_rden(issue_rs2_rden),
    .issue_rd_addr (issue_rd_addr),
    .issue_rd_wren (issue_rd_wren),
    .wb_rd_addr    (wb_rd_addr),
    .wb_rd_wren    (wb_rd_wren),
    .flush         (flush),
    .busy          (busy),
    .pending_cnt   (pending_cnt),
    .wb_err        (wb_err),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {SigBusy, SigCnt, SigErr, SigStall} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_next(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_state(input string tag, input logic [31:0] b, input int c);
    expect_next({tag, "_busy"}, SigBusy, b);
    expect_next({tag, "_cnt"}, SigCnt, 32'(c));
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sig)
        SigBusy:  check_eq(e.tag, busy, e.exp);
        SigCnt:   check_eq(e.tag, 32'(pending_cnt), e.exp);
        SigErr:   check_eq(e.tag, 32'(wb_err), e.exp);
        default:  check_eq(e.tag, stall_cnt, e.exp);
      endcase
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic rs1en,
                       input logic [4:0] rs2, input logic rs2en, input logic [4:0] rd,
                       input logic rdwen, input logic [4:0] wb, input logic wben,
                       input logic fl);
    issue_valid    = v;
    issue_rs1_addr = rs1;
    issue_rs1_rden = rs1en;
    issue_rs2_addr = rs2;
    issue_rs2_rden = rs2en;
    issue_rd_addr  = rd;
    issue_rd_wren  = rdwen;
    wb_rd_addr     = wb;
    wb_rd_wren     = wben;
    flush          = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic wb_only(input logic [4:0] wb);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, wb, 1'b1, 1'b0);
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check_eq(tag, 32'(issue_ready), 32'(exp));
  endtask

  function automatic logic [31:0] bm(input int n);
    return 32'h1 << n;
  endfunction

  logic [31:0] acc;
  int unsigned drain_regs[4] = '{1, 3, 4, 8};

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_cnt", 32'(pending_cnt), 32'd0);
    check_eq("rst_err", 32'(wb_err), 32'd0);
    check_eq("rst_stall", stall_cnt, 32'd0);
    check_ready("rst_ready", 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // RAW on rs1 and rs2, then bypassed by same-cycle writeback
    issue_rd(5'd5);
    check_ready("raw_issue", 1'b1);
    expect_state("raw_set", bm(5), 1);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ready("raw_rs1_stall", 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ready("raw_rs2_stall", 1'b0);
    expect_state("raw_hold", bm(5), 1);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    check_ready("raw_wb_bypass", 1'b1);
    expect_state("raw_clear", 32'd0, 0);
    expect_next("raw_err", SigErr, 32'd0);
    step();

    // WAW with set-wins
    issue_rd(5'd7);
    check_ready("waw_first", 1'b1);
    expect_state("waw_first", bm(7), 1);
    step();
    issue_rd(5'd7);
    check_ready("waw_stall", 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
    check_ready("waw_wb", 1'b1);
    expect_state("waw_set_wins", bm(7), 1);
    step();
    wb_only(5'd7);
    expect_state("waw_drain", 32'd0, 0);
    step();

    // Set and clear of different registers in one cycle
    issue_rd(5'd10);
    expect_state("diff_a", bm(10), 1);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 5'd10, 1'b1, 1'b0);
    check_ready("diff_ready", 1'b1);
    expect_state("diff_swap", bm(11), 1);
    step();
    wb_only(5'd11);
    expect_state("diff_drain", 32'd0, 0);
    step();

    // Capacity
    acc = 32'd0;
    for (int i = 1; i <= 4; i++) begin
      issue_rd(5'(i));
      check_ready("cap_fill_ready", 1'b1);
      acc = acc | bm(i);
      expect_state("cap_fill", acc, i);
      step();
    end
    issue_rd(5'd8);
    check_ready("cap_full", 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_ready("cap_nowrite", 1'b1);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 5'd2, 1'b1, 1'b0);
    check_ready("cap_wb_frees", 1'b1);
    acc = bm(1) | bm(3) | bm(4) | bm(8);
    expect_state("cap_swap", acc, 4);
    step();
    for (int i = 0; i < 4; i++) begin
      wb_only(5'(drain_regs[i]));
      acc = acc & ~bm(int'(drain_regs[i]));
      expect_state("cap_drain", acc, 3 - i);
      step();
    end

    // x0 is never tracked
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      check_ready("x0_ready", 1'b1);
      expect_state("x0_state", 32'd0, 0);
      step();
    end
    wb_only(5'd0);
    expect_next("x0_wb_err", SigErr, 32'd0);
    expect_state("x0_wb", 32'd0, 0);
    step();

    // Flush, then writeback to a now-idle register
    issue_rd(5'd3);
    expect_state("fl_a", bm(3), 1);
    step();
    issue_rd(5'd9);
    expect_state("fl_b", bm(3) | bm(9), 2);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 5'd5, 1'b1, 1'b1);
    check_ready("flush_ready", 1'b0);
    expect_state("flush_clear", 32'd0, 0);
    expect_next("flush_no_err", SigErr, 32'd0);
    step();
    wb_only(5'd3);
    expect_next("wb_nonbusy_err", SigErr, 32'd1);
    expect_state("wb_nonbusy", 32'd0, 0);
    step();
    idle();
    expect_next("err_sticky", SigErr, 32'd1);
    step();

    // Asynchronous reset mid-operation
    issue_rd(5'd6);
    expect_state("pre_rst", bm(6), 1);
    step();
    idle();
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 32'd0);
    check_eq("arst_cnt", 32'(pending_cnt), 32'd0);
    check_eq("arst_err", 32'(wb_err), 32'd0);
    check_eq("arst_stall", stall_cnt, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Stall counter
    issue_rd(5'd5);
    check_ready("perf_issue", 1'b1);
    expect_state("perf_set", bm(5), 1);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_ready("perf_stall_ready", 1'b0);
      if (i == 5) expect_next("perf_stall_cnt", SigStall, PerfExp);
      step();
    end
    idle();
    expect_next("perf_idle_hold", SigStall, PerfExp);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter: MAX_PENDING, 4, maximum outstanding register writes (legal range 1..31).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: issue_valid  input  1  decode presents an instruction.
REQ-005 SHALL have port: issue_ready  output  1  scoreboard accepts it (combinational).
REQ-006 SHALL have ports: issue_rs1_addr, issue_rs2_addr  input  5 each  source register addresses.
REQ-007 SHALL have ports: issue_rs1_rden, issue_rs2_rden  input  1 each  source actually read.
REQ-008 SHALL have ports: issue_rd_addr  input  5, issue_rd_wren  input  1  destination of the issuing instruction.
REQ-009 SHALL have ports: wb_rd_addr  input  5, wb_rd_wren  input  1  writeback port, identical to the register-file write port.
REQ-010 SHALL have port: flush  input  1  discard all pending writes.
REQ-011 SHALL have port: busy  output  32  per-register pending-write bit; bit 0 always 0.
REQ-012 SHALL have port: pending_cnt  output  $clog2(MAX_PENDING+1)  outstanding-write count.
REQ-013 SHALL have port: wb_err  output  1  sticky: writeback to a non-busy register seen.
REQ-014 SHALL have port: stall_cnt  output  32  stall-cycle performance counter.

Function
REQ-015 SHALL define wb_hit(x) = wb_rd_wren && wb_rd_addr==x && x!=0 (same-cycle writeback is forwarded by the register-file bypass, so never a hazard).
REQ-016 SHALL flag RAW hazard on rsN when issue_rsN_rden && rsN!=0 && busy[rsN] && !wb_hit(rsN).
REQ-017 SHALL flag WAW hazard when issue_rd_wren && rd!=0 && busy[rd] && !wb_hit(rd).
REQ-018 SHALL flag capacity stall when issue_rd_wren && rd!=0 && pending_cnt==MAX_PENDING && !(wb_rd_wren && wb_rd_addr!=0 && busy[wb_rd_addr]).
REQ-019 SHALL drive issue_ready = !flush && no RAW, WAW or capacity condition; independent of issue_valid.
REQ-020 SHALL, on accept (issue_valid && issue_ready) with issue_rd_wren && rd!=0, set busy[rd] and add 1 to pending_cnt next cycle.
REQ-021 SHALL, on wb_rd_wren && wb_rd_addr!=0 && busy[wb_rd_addr], clear that bit and subtract 1 from pending_cnt next cycle.
REQ-022 SHALL, on wb to non-busy nonzero register, leave state unchanged and set wb_err until reset.
REQ-023 SHALL, on simultaneous accept-set and wb-clear of the same register, leave busy bit set (set wins) and pending_cnt unchanged.
REQ-024 SHALL, on simultaneous set and clear of different registers, update both bits and leave pending_cnt unchanged.
REQ-025 SHALL, when flush=1, clear all busy bits and pending_cnt next cycle; issue and writeback in that cycle are ignored; wb_err is not set in that cycle.
REQ-026 SHALL ignore rd=0 and wb_rd_addr=0 entirely; pending_cnt never exceeds MAX_PENDING nor underflows.
REQ-027 SHALL have zero-cycle issue latency: hazard decision uses current busy plus current writeback only.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force busy=0, pending_cnt=0, wb_err=0, stall_cnt=0; issue_ready then follows REQ-019 with empty state.
REQ-029 SHALL, on reset mid-operation, drop all pending writes; no state survives reset.

Configuration
REQ-030 SHALL, with SCOREBOARD_PERF_EN defined, increment stall_cnt each cycle with issue_valid && !issue_ready, saturating at 32'hFFFF_FFFF, counting flush cycles too.
REQ-031 SHALL, without SCOREBOARD_PERF_EN, tie stall_cnt to 0 and instantiate no counter flop.

Verification
REQ-032 SHALL test RAW: issue rd=5; next cycle issue rs1=5 rden=1 with no wb -> issue_ready=0; wb x5 in same cycle -> issue_ready=1, busy[5]=0 next cycle.
REQ-033 SHALL test WAW with set-wins: busy[7]=1; issue rd=7 with wb x7 same cycle -> accepted, busy[7]=1, pending_cnt unchanged.
REQ-034 SHALL test capacity: issue rd=1..4 -> pending_cnt=4; issue rd=8 -> issue_ready=0; wb x2 same cycle -> accepted, pending_cnt=4.
REQ-035 SHALL test x0: issue rd=0 and rs1=0 rden=1 repeatedly -> issue_ready=1, busy=0, pending_cnt=0; wb x0 -> wb_err=0.
REQ-036 SHALL test flush: busy={3,9}, flush=1 with issue rd=12 -> issue_ready=0, next cycle busy=0, pending_cnt=0; wb x3 afterwards -> wb_err=1.
REQ-037 SHALL test perf: SCOREBOARD_PERF_EN defined, 6 stalled valid cycles -> stall_cnt=6; undefined -> stall_cnt=0.
